// File: rtl/fft_hdmi_fifo_pkg.sv
// Shared types and helpers for the fft_hdmi async FIFO.
// Pointer helpers work at the widest supported pointer width; callers cast to their own width.
package fft_hdmi_fifo_pkg;

  localparam int ADDR_WIDTH_DFLT = 9;
  localparam int DEPTH           = 2**ADDR_WIDTH_DFLT;
  localparam int PTR_W           = ADDR_WIDTH_DFLT + 1;
  localparam int PTR_W_MAX       = 11;

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Zero-extended inputs decode correctly because the leading zeros leave the prefix unchanged.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fft_hdmi_fifo_wr_ctrl_if.sv
// Write-side bus of the fft_hdmi FIFO: push request, RAM write port, pointers and status.
interface fft_hdmi_fifo_wr_ctrl_if #(parameter int ADDR_WIDTH = 9);

  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic                  wr_full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_water_level;
  logic                  wr_overflow;

  modport master (
    input  wr_en, rd_ptr_gray,
    output ram_wr_addr, ram_wr_en, wr_ptr_gray, wr_full, almost_full,
           wr_water_level, wr_overflow
  );

  modport slave (
    output wr_en, rd_ptr_gray,
    input  ram_wr_addr, ram_wr_en, wr_ptr_gray, wr_full, almost_full,
           wr_water_level, wr_overflow
  );

endinterface

// File: rtl/fft_hdmi_fifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module fft_hdmi_fifo_gray_sync #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             asyn_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge i_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/fft_hdmi_fifo_wr_ctrl.sv
// Write-side controller of the fft_hdmi async FIFO: RAM write port, Gray write pointer,
// and full / almost_full / level / overflow derived from the synchronised read pointer.
module fft_hdmi_fifo_wr_ctrl
  import fft_hdmi_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH      = 9,
  parameter int ALMOST_FULL_NUM = 2**ADDR_WIDTH - 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                      wr_clk,
  input  logic                      asyn_rst,
  fft_hdmi_fifo_wr_ctrl_if.master   bus
);

  localparam int AW = ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_wr_bin;
  logic [PW-1:0] r_wr_gray;
  logic          r_wr_full;
  logic          r_almost_full;
  logic [PW-1:0] r_water_level;
  logic          r_overflow;

  logic          w_accept;
  logic [PW-1:0] w_bin_nxt;
  logic [PW-1:0] w_gray_nxt;
  logic [PW-1:0] w_rd_gray_s;
  logic [PW-1:0] w_rd_bin_s;
  logic [PW-1:0] w_level_nxt;
  logic [PW-1:0] w_full_gray;

  fft_hdmi_fifo_gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .i_clk    (wr_clk),
    .asyn_rst (asyn_rst),
    .i_d      (bus.rd_ptr_gray),
    .o_q      (w_rd_gray_s)
  );

  assign w_accept    = bus.wr_en & ~r_wr_full;
  assign w_bin_nxt   = r_wr_bin + PW'(w_accept);
  assign w_gray_nxt  = PW'(bin2gray(PTR_W_MAX'(w_bin_nxt)));
  assign w_rd_bin_s  = PW'(gray2bin(PTR_W_MAX'(w_rd_gray_s)));
  assign w_level_nxt = w_bin_nxt - w_rd_bin_s;

  // Full in Gray space: top two bits inverted means exactly one lap ahead of the reader.
  assign w_full_gray = {~w_rd_gray_s[AW:AW-1], w_rd_gray_s[AW-2:0]};

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_wr_bin      <= '0;
      r_wr_gray     <= '0;
      r_wr_full     <= 1'b0;
      r_almost_full <= 1'b0;
      r_water_level <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_bin      <= w_bin_nxt;
      r_wr_gray     <= w_gray_nxt;
      r_wr_full     <= (w_gray_nxt == w_full_gray);
      r_almost_full <= (w_level_nxt >= PW'(ALMOST_FULL_NUM));
      r_water_level <= w_level_nxt;
      r_overflow    <= bus.wr_en & r_wr_full;
    end
  end

  assign bus.ram_wr_en      = w_accept;
  assign bus.ram_wr_addr    = r_wr_bin[AW-1:0];
  assign bus.wr_ptr_gray    = r_wr_gray;
  assign bus.wr_full        = r_wr_full;
  assign bus.almost_full    = r_almost_full;
  assign bus.wr_water_level = r_water_level;
  assign bus.wr_overflow    = r_overflow;

endmodule

// File: tb/tb_fft_hdmi_fifo_wr_ctrl.sv
// Bench for fft_hdmi_fifo_wr_ctrl: reference model plus an address scoreboard.
module tb_fft_hdmi_fifo_wr_ctrl;

  localparam int AW = 4;
  localparam int PW = 5;

  logic wr_clk   = 1'b0;
  logic asyn_rst = 1'b0;

  fft_hdmi_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fft_hdmi_fifo_wr_ctrl #(
    .ADDR_WIDTH      (AW),
    .ALMOST_FULL_NUM (14),
    .SYNC_STAGES     (2)
  ) dut (
    .wr_clk   (wr_clk),
    .asyn_rst (asyn_rst),
    .bus      (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [AW-1:0] exp_q [$];
  logic [PW-1:0] m_bin, m_rs1, m_rs2, m_lvl, rd_drv, prev_gray;
  logic          m_full, m_af, m_ovf;
  logic          any_full, saw_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] tb_b2g(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  task automatic model_reset();
    m_bin  = '0;
    m_rs1  = '0;
    m_rs2  = '0;
    m_lvl  = '0;
    rd_drv = '0;
    m_full = 1'b0;
    m_af   = 1'b0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_addr"},  32'(bus.ram_wr_addr),    0);
    chk({pfx, "_gray"},  32'(bus.wr_ptr_gray),    0);
    chk({pfx, "_full"},  32'(bus.wr_full),        0);
    chk({pfx, "_af"},    32'(bus.almost_full),    0);
    chk({pfx, "_level"}, 32'(bus.wr_water_level), 0);
    chk({pfx, "_ovf"},   32'(bus.wr_overflow),    0);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic en);
    logic          acc;
    logic [PW-1:0] nb, lvl;
    logic [AW-1:0] a;
    bus.wr_en       = en;
    bus.rd_ptr_gray = tb_b2g(rd_drv);
    #1;
    acc = en & ~m_full;
    if (acc) exp_q.push_back(m_bin[AW-1:0]);
    chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(acc));
    if (bus.ram_wr_en) begin
      if (exp_q.size() == 0) chk("sb_underrun", 32'(exp_q.size()), 1);
      else begin
        a = exp_q.pop_front();
        chk("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(a));
      end
    end
    @(posedge wr_clk);
    nb     = m_bin + PW'(acc);
    lvl    = nb - m_rs2;
    m_ovf  = en & m_full;
    m_full = (lvl == 5'd16);
    m_af   = (lvl >= 5'd14);
    m_lvl  = lvl;
    m_bin  = nb;
    m_rs2  = m_rs1;
    m_rs1  = rd_drv;
    @(negedge wr_clk);
    #1;
    chk("wr_full",        32'(bus.wr_full),        32'(m_full));
    chk("almost_full",    32'(bus.almost_full),    32'(m_af));
    chk("wr_water_level", 32'(bus.wr_water_level), 32'(m_lvl));
    chk("wr_ptr_gray",    32'(bus.wr_ptr_gray),    32'(tb_b2g(m_bin)));
    chk("wr_overflow",    32'(bus.wr_overflow),    32'(m_ovf));
    any_full = any_full | bus.wr_full;
    if (prev_gray == 5'b10000 && bus.wr_ptr_gray == 5'b00000) saw_wrap = 1'b1;
    prev_gray = bus.wr_ptr_gray;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en       = 1'b0;
    bus.rd_ptr_gray = '0;
    model_reset();
    any_full  = 1'b0;
    saw_wrap  = 1'b0;
    prev_gray = '0;

    // Reset asserted between edges must clear outputs without a clock.
    #2 asyn_rst = 1'b1;
    #1 chk_all_zero("rst");
    @(negedge wr_clk);
    @(negedge wr_clk);
    asyn_rst = 1'b0;
    #1;
    chk("rel_addr", 32'(bus.ram_wr_addr), 0);
    chk("rel_full", 32'(bus.wr_full), 0);

    // Fill with reader parked at 0.
    for (int i = 0; i < 16; i++) begin
      step(1'b1);
      if (i == 12) chk("af_after13", 32'(bus.almost_full), 0);
      if (i == 13) chk("af_after14", 32'(bus.almost_full), 1);
    end
    chk("fill_full",  32'(bus.wr_full), 1);
    chk("fill_level", 32'(bus.wr_water_level), 16);
    chk("fill_gray",  32'(bus.wr_ptr_gray), 32'h18);

    // Push at full is rejected and flagged each cycle.
    step(1'b1);
    chk("ovf_1", 32'(bus.wr_overflow), 1);
    step(1'b1);
    chk("ovf_2", 32'(bus.wr_overflow), 1);
    chk("ovf_gray", 32'(bus.wr_ptr_gray), 32'h18);
    step(1'b0);
    chk("ovf_clear", 32'(bus.wr_overflow), 0);

    // Reader advances to 4: full drops only after the sync latency.
    rd_drv = 5'd4;
    step(1'b0);
    step(1'b0);
    chk("drain_full_still", 32'(bus.wr_full), 1);
    step(1'b0);
    chk("drain_full",  32'(bus.wr_full), 0);
    chk("drain_level", 32'(bus.wr_water_level), 12);
    chk("drain_af",    32'(bus.almost_full), 0);

    // Streaming across the pointer wrap with a trailing reader.
    any_full  = 1'b0;
    saw_wrap  = 1'b0;
    prev_gray = bus.wr_ptr_gray;
    for (int i = 0; i < 40; i++) begin
      rd_drv = m_bin - 5'd3;
      step(1'b1);
    end
    chk("wrap_seen",    32'(saw_wrap), 1);
    chk("wrap_no_full", 32'(any_full), 0);
    chk("wrap_sb_empty", 32'(exp_q.size()), 0);

    // Settle to a level of 9, then reset mid-operation.
    rd_drv = m_bin - 5'd9;
    repeat (3) step(1'b0);
    chk("pre_rst_level", 32'(bus.wr_water_level), 9);
    #2 asyn_rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    model_reset();
    bus.rd_ptr_gray = '0;
    @(negedge wr_clk);
    asyn_rst = 1'b0;
    #1;
    step(1'b1);
    chk("post_rst_gray", 32'(bus.wr_ptr_gray), 32'(tb_b2g(5'd1)));
    step(1'b1);
    step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
